// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - baud table, config layout and FSM states for the UART transmitter
package uart_pkg;

  localparam logic [3:0] BAUD_300    = 4'd0;
  localparam logic [3:0] BAUD_600    = 4'd1;
  localparam logic [3:0] BAUD_1200   = 4'd2;
  localparam logic [3:0] BAUD_2400   = 4'd3;
  localparam logic [3:0] BAUD_4800   = 4'd4;
  localparam logic [3:0] BAUD_9600   = 4'd5;
  localparam logic [3:0] BAUD_14400  = 4'd6;
  localparam logic [3:0] BAUD_19200  = 4'd7;
  localparam logic [3:0] BAUD_28800  = 4'd8;
  localparam logic [3:0] BAUD_38400  = 4'd9;
  localparam logic [3:0] BAUD_57600  = 4'd10;
  localparam logic [3:0] BAUD_115200 = 4'd11;
  localparam int unsigned NUM_BAUDS  = 12;

  localparam int CFG_BAUD_LSB   = 0;
  localparam int CFG_BAUD_MSB   = 3;
  localparam int CFG_PARITY_EN  = 4;
  localparam int CFG_PARITY_ODD = 5;
  localparam int CFG_TWO_STOP   = 6;

  typedef struct packed {
    logic       two_stop;
    logic       parity_odd;
    logic       parity_en;
    logic [3:0] baud;
  } tx_cfg_t;

  localparam tx_cfg_t CFG_RESET = '{two_stop: 1'b0, parity_odd: 1'b0, parity_en: 1'b0, baud: BAUD_115200};

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  function automatic int unsigned baud_rate(input logic [3:0] idx);
    int unsigned rate;
    case (idx)
      BAUD_300:   rate = 300;
      BAUD_600:   rate = 600;
      BAUD_1200:  rate = 1200;
      BAUD_2400:  rate = 2400;
      BAUD_4800:  rate = 4800;
      BAUD_9600:  rate = 9600;
      BAUD_14400: rate = 14400;
      BAUD_19200: rate = 19200;
      BAUD_28800: rate = 28800;
      BAUD_38400: rate = 38400;
      BAUD_57600: rate = 57600;
      default:    rate = 115200;
    endcase
    return rate;
  endfunction

  // Rounded to nearest so the bit-time error stays within half a clock.
  function automatic int unsigned baud_divisor(input int unsigned clk_hz, input logic [3:0] idx);
    int unsigned rate;
    rate = baud_rate(idx);
    return (clk_hz + rate / 2) / rate;
  endfunction

  function automatic tx_cfg_t decode_cfg(input logic [6:0] raw);
    tx_cfg_t c;
    c.baud       = raw[CFG_BAUD_MSB:CFG_BAUD_LSB];
    c.parity_en  = raw[CFG_PARITY_EN];
    c.parity_odd = raw[CFG_PARITY_ODD];
    c.two_stop   = raw[CFG_TWO_STOP];
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO with extra-MSB pointers
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO lands in the slot the same-cycle pop is vacating.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with write FIFO, runtime frame config and status flags
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic                 write_enable,
  input  logic [7:0]           config_data,
  input  logic                 config_enable,
  output logic                 tx_line,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 busy,
  output logic                 overflow,
  output logic                 config_error
);

  localparam int unsigned MAX_DIV  = baud_divisor(CLK_HZ, BAUD_300);
  localparam int unsigned DIV_W    = $clog2(MAX_DIV + 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic [DIV_W-1:0] div_table [16];
  for (genvar i = 0; i < 16; i++) begin : g_div
    assign div_table[i] = DIV_W'(baud_divisor(CLK_HZ, 4'(i)));
  end

  tx_state_e              state_q, state_d;
  logic [DIV_W-1:0]       baud_cnt_q, baud_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;
  tx_cfg_t                active_q, pend_q, frame_cfg;
  logic                   pend_valid_q, cfg_err_q, overflow_q;
  logic                   cfg_legal, cfg_apply, cfg_reserved_unused;
  logic                   pop, load, bit_done, fifo_drop;
  logic [DIV_W-1:0]       cur_div;
  logic [DATA_BITS-1:0]   fifo_rdata;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (write_enable),
    .data_i  (write_data),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign cfg_reserved_unused = config_data[7];
  assign cfg_legal = (config_data[CFG_BAUD_MSB:CFG_BAUD_LSB] < 4'(NUM_BAUDS));
  // Pending config only takes effect while idle, so a frame never sees a mid-flight change.
  assign cfg_apply = (state_q == IDLE) && pend_valid_q;
  assign frame_cfg = cfg_apply ? pend_q : active_q;
  assign cur_div   = div_table[frame_cfg.baud];
  assign bit_done  = (baud_cnt_q == cur_div - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q     <= CFG_RESET;
      pend_q       <= CFG_RESET;
      pend_valid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      cfg_err_q  <= config_enable && !cfg_legal;
      overflow_q <= fifo_drop;
      if (cfg_apply) begin
        active_q     <= pend_q;
        pend_valid_q <= 1'b0;
      end
      if (config_enable && cfg_legal) begin
        pend_q       <= decode_cfg(config_data[6:0]);
        pend_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    load       = 1'b0;
    pop        = 1'b0;
    tx_d       = 1'b1;
    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        load       = !fifo_empty;
      end
      START: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = frame_cfg.parity_en ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (frame_cfg.two_stop && (bit_cnt_q == 3'd0)) begin
            bit_cnt_d = 3'd1;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pop        = 1'b1;
      shift_d    = fifo_rdata;
      parity_d   = (^fifo_rdata) ^ frame_cfg.parity_odd;
      bit_cnt_d  = '0;
      baud_cnt_d = '0;
      state_d    = START;
    end

    // Line level is registered from the next state so the pin never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_line      = tx_q;
  assign busy         = (state_q != IDLE);
  assign overflow     = overflow_q;
  assign config_error = cfg_err_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo against a frame-level model
module tb_uart_tx_fifo;

  localparam int unsigned CLK_HZ    = 1_152_000;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned DEPTH     = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] write_data = '0;
  logic       write_enable = 1'b0;
  logic [7:0] config_data = '0;
  logic       config_enable = 1'b0;
  logic       tx_line, fifo_full, fifo_empty, busy, overflow, config_error;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .write_data    (write_data),
    .write_enable  (write_enable),
    .config_data   (config_data),
    .config_enable (config_enable),
    .tx_line       (tx_line),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .busy          (busy),
    .overflow      (overflow),
    .config_error  (config_error)
  );

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level reference: a byte queue plus the bit list of the frame on the line.
  int         rates [12] = '{300, 600, 1200, 2400, 4800, 9600, 14400, 19200, 28800, 38400, 57600, 115200};
  logic [7:0] m_fifo [$];
  bit         m_bits [$];
  int         m_div, m_pos, m_len;
  bit         m_busy, m_pend_v, m_ovf, m_cerr, m_pop, m_done, m_idle;
  logic [6:0] m_act, m_pend;
  logic [7:0] m_byte;

  function automatic int div_of(input logic [3:0] idx);
    return (CLK_HZ + rates[idx] / 2) / rates[idx];
  endfunction

  function automatic void start_frame(input logic [7:0] b, input logic [6:0] cfg);
    m_bits.delete();
    m_bits.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) m_bits.push_back(b[i]);
    if (cfg[4]) m_bits.push_back((^b) ^ cfg[5]);
    m_bits.push_back(1'b1);
    if (cfg[6]) m_bits.push_back(1'b1);
    m_div  = div_of(cfg[3:0]);
    m_len  = m_bits.size() * m_div;
    m_pos  = 0;
    m_busy = 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      m_busy = 1'b0; m_pos = 0; m_act = 7'h0B; m_pend_v = 1'b0; m_ovf = 1'b0; m_cerr = 1'b0;
    end else begin
      m_idle = !m_busy;
      m_done = m_busy && (m_pos == m_len - 1);
      if (m_idle && m_pend_v) begin
        m_act = m_pend;
        m_pend_v = 1'b0;
      end
      m_pop  = (m_fifo.size() != 0) && (m_idle || m_done);
      m_ovf  = write_enable && (m_fifo.size() == DEPTH) && !m_pop;
      m_cerr = config_enable && (config_data[3:0] >= 4'd12);
      if (config_enable && !m_cerr) begin
        m_pend = config_data[6:0];
        m_pend_v = 1'b1;
      end
      if (m_pop) begin
        m_byte = m_fifo.pop_front();
        start_frame(m_byte, m_act);
      end else if (m_done) m_busy = 1'b0;
      else if (m_busy) m_pos++;
      if (write_enable && !m_ovf) m_fifo.push_back(write_data);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("tx_line", tx_line, m_busy ? m_bits[m_pos / m_div] : 1'b1);
      check("busy", busy, m_busy);
      check("fifo_empty", fifo_empty, m_fifo.size() == 0);
      check("fifo_full", fifo_full, m_fifo.size() == DEPTH);
      check("overflow", overflow, m_ovf);
      check("config_error", config_error, m_cerr);
    end
  end

  task automatic put(input logic [7:0] b);
    write_data = b;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] c);
    config_data = c;
    config_enable = 1'b1;
    @(negedge clk);
    config_enable = 1'b0;
  endtask

  task automatic busy_run(output int len);
    int t = 0;
    len = 0;
    while (!busy && t < 400) begin @(negedge clk); t++; end
    while (busy && len < 3000) begin @(negedge clk); len++; end
  endtask

  task automatic expect_frame(input string name, input logic [11:0] bits, input int nbits, input int div);
    @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      check(name, tx_line, bits[k]);
      repeat (div) @(negedge clk);
    end
    check({name, "_end_busy"}, busy, 1'b0);
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while ((busy || !fifo_empty) && t < limit) begin @(negedge clk); t++; end
    check("drain_done", busy || !fifo_empty, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int len;
    #3 rst = 1'b1;
    #1;
    check("rst_tx", tx_line, 1'b1);
    check("rst_empty", fifo_empty, 1'b1);
    check("rst_full", fifo_full, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_cerr", config_error, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    put(8'h55);
    check("lat_empty", fifo_empty, 1'b0);
    check("lat_busy", busy, 1'b0);
    expect_frame("frame55", 12'h2AA, 10, 10);
    check("frame55_empty", fifo_empty, 1'b1);

    fork
      busy_run(len);
      begin put(8'h41); put(8'h42); put(8'h43); end
    join
    check("b2b_len", len, 300);

    cfg(8'h7B);
    put(8'h03);
    expect_frame("parity_frame", 12'hE06, 12, 10);
    cfg(8'h0B);
    repeat (2) @(negedge clk);

    put(8'h10);
    @(negedge clk);
    for (int i = 0; i < 16; i++) put(8'h20 + 8'(i));
    check("full_16", fifo_full, 1'b1);
    put(8'hEE);
    check("ovf_pulse", overflow, 1'b1);
    @(negedge clk);
    check("ovf_clear", overflow, 1'b0);
    repeat (81) @(negedge clk);
    put(8'h77);
    check("popwrite_ovf", overflow, 1'b0);
    check("popwrite_full", fifo_full, 1'b1);
    drain(2500);

    cfg(8'h0C);
    check("cerr_pulse", config_error, 1'b1);
    @(negedge clk);
    check("cerr_clear", config_error, 1'b0);
    fork busy_run(len); put(8'hA5); join
    check("bad_cfg_len", len, 100);
    fork
      busy_run(len);
      begin put(8'h3C); repeat (30) @(negedge clk); cfg(8'h0A); end
    join
    check("midframe_cfg_len", len, 100);
    fork busy_run(len); put(8'hC3); join
    check("div20_len", len, 200);

    cfg(8'h7A);
    put(8'h99); put(8'h11); put(8'h22);
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", tx_line, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_empty", fifo_empty, 1'b1);
    check("midrst_full", fifo_full, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fork busy_run(len); put(8'h5A); join
    check("post_rst_len", len, 100);

    for (int c = 0; c < 3000; c++) begin
      write_enable  = ($urandom_range(0, 3) == 0);
      write_data    = 8'($urandom);
      config_enable = ($urandom_range(0, 299) == 0);
      config_data   = {1'($urandom), 3'($urandom), 4'(9 + $urandom_range(0, 6))};
      @(negedge clk);
    end
    write_enable  = 1'b0;
    config_enable = 1'b0;
    drain(8000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
